// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine controller: FSM state encoding
// and coin values expressed in nickel units.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } vend_state_e;

    localparam logic [2:0] NICKEL_U  = 3'd1;
    localparam logic [2:0] DIME_U    = 3'd2;
    localparam logic [2:0] QUARTER_U = 3'd5;

endpackage

// File: rtl/vend_coin_arb.sv
// Coin arbiter: picks at most one coin per cycle (quarter > dime > nickel)
// and flags every other coin for return. While the controller is busy or a
// cancel is being honoured, every coin is returned.
module coin_arb
    import vend_pkg::*;
(
    input  logic       nb,
    input  logic       db,
    input  logic       qb,
    input  logic       cancel,
    input  logic       busy,
    output logic [2:0] coin_val,
    output logic       coin_rej
);

    // Priority select of the accepted coin and rejection of the losers.
    always_comb begin
        coin_val = 3'd0;
        coin_rej = 1'b0;
        if (busy || cancel) begin
            coin_rej = nb | db | qb;
        end else if (qb) begin
            coin_val = QUARTER_U;
            coin_rej = nb | db;
        end else if (db) begin
            coin_val = DIME_U;
            coin_rej = nb;
        end else if (nb) begin
            coin_val = NICKEL_U;
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine controller: accumulates credit in nickel units, issues one
// vend pulse when PRICE_N is reached, then pays the remainder back as dimes
// followed by at most one nickel.
// Optional feature macro VEND_CANCEL_EN: when defined, cancel in ACCUM
// returns all credit through the normal payout; otherwise cancel is ignored.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE_N = 5,
    parameter int CW      = $clog2(PRICE_N + 5)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          nb,
    input  logic          db,
    input  logic          qb,
    input  logic          cancel,
    output logic          vend,
    output logic          chg_n,
    output logic          chg_d,
    output logic          reject,
    output logic          busy,
    output logic [CW-1:0] credit
);

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE_N);
    localparam logic [CW-1:0] TWO_C   = CW'(2);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    vend_state_e   state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [CW-1:0] sum;
    logic          reject_q;
    logic [2:0]    coin_val;
    logic          coin_rej;
    logic          cancel_eff;

`ifdef VEND_CANCEL_EN
    // Cancel only means something while credit is being accumulated.
    assign cancel_eff = cancel & (state_q == ACCUM);
`else
    assign cancel_eff = cancel & 1'b0;
`endif

    assign busy   = (state_q == VEND) || (state_q == CHANGE);
    assign credit = credit_q;
    assign reject = reject_q;
    assign sum    = credit_q + CW'(coin_val);

    coin_arb u_arb (
        .nb       (nb),
        .db       (db),
        .qb       (qb),
        .cancel   (cancel_eff),
        .busy     (busy),
        .coin_val (coin_val),
        .coin_rej (coin_rej)
    );

    // Next-state, credit update and payout decode from registered state only.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        vend     = 1'b0;
        chg_d    = 1'b0;
        chg_n    = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                if (cancel_eff) begin
                    state_d = CHANGE;
                end else if (coin_val != 3'd0) begin
                    credit_d = sum;
                    state_d  = (sum >= PRICE_C) ? VEND : ACCUM;
                end
            end
            VEND: begin
                vend     = 1'b1;
                credit_d = credit_q - PRICE_C;
                state_d  = (credit_q == PRICE_C) ? IDLE : CHANGE;
            end
            CHANGE: begin
                if (credit_q >= TWO_C) begin
                    chg_d    = 1'b1;
                    credit_d = credit_q - TWO_C;
                    state_d  = (credit_q == TWO_C) ? IDLE : CHANGE;
                end else if (credit_q == ONE_C) begin
                    chg_n    = 1'b1;
                    credit_d = '0;
                    state_d  = IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    // State, credit and registered reject pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= coin_rej;
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Testbench for vend_ctrl (PRICE_N = 5). A transaction-level model predicts
// the visible outputs each cycle: a sale or cancel is turned into a queue of
// future cycles (vend, then dimes, then an odd nickel) that is replayed.
module tb_vend_ctrl;

    localparam int P  = 5;
    localparam int CW = $clog2(P + 5);

    logic          clk = 1'b0;
    logic          rst, nb, db, qb, cancel;
    logic          vend, chg_n, chg_d, reject, busy;
    logic [CW-1:0] credit;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    vend_ctrl #(.PRICE_N(P)) dut (
        .clk    (clk),
        .rst    (rst),
        .nb     (nb),
        .db     (db),
        .qb     (qb),
        .cancel (cancel),
        .vend   (vend),
        .chg_n  (chg_n),
        .chg_d  (chg_d),
        .reject (reject),
        .busy   (busy),
        .credit (credit)
    );

    typedef struct {
        bit v;
        bit d;
        bit n;
        int cr;
    } step_t;

    step_t q[$];
    bit    m_busy, m_v, m_d, m_n, m_rej;
    int    m_cr;

    // Queue the change cycles for k units: dimes first, then one nickel.
    task automatic plan_payout(input int k);
        int    rem;
        step_t s;
        rem = k;
        while (rem >= 2) begin
            s = '{v: 1'b0, d: 1'b1, n: 1'b0, cr: rem};
            q.push_back(s);
            rem -= 2;
        end
        if (rem == 1) begin
            s = '{v: 1'b0, d: 1'b0, n: 1'b1, cr: 1};
            q.push_back(s);
        end
    endtask

    task automatic model_edge(input bit r, input bit bn, input bit bd, input bit bq, input bit bc);
        int    coins, val, nw;
        bit    ce;
        step_t s;
        coins = int'(bn) + int'(bd) + int'(bq);
        if (r) begin
            q.delete();
            m_busy = 0; m_v = 0; m_d = 0; m_n = 0; m_rej = 0; m_cr = 0;
            return;
        end
`ifdef VEND_CANCEL_EN
        ce = bc && !m_busy && (m_cr > 0);
`else
        ce = 1'b0;
`endif
        m_rej = (m_busy || ce) ? (coins > 0) : (coins > 1);
        if (!m_busy) begin
            if (ce) begin
                plan_payout(m_cr);
            end else if (coins > 0) begin
                val = bq ? 5 : (bd ? 2 : 1);
                nw  = m_cr + val;
                if (nw >= P) begin
                    s = '{v: 1'b1, d: 1'b0, n: 1'b0, cr: nw};
                    q.push_back(s);
                    plan_payout(nw - P);
                end else begin
                    m_cr = nw;
                end
            end
        end
        if (q.size() > 0) begin
            s = q.pop_front();
            m_busy = 1; m_v = s.v; m_d = s.d; m_n = s.n; m_cr = s.cr;
        end else begin
            if (m_busy) m_cr = 0;
            m_busy = 0; m_v = 0; m_d = 0; m_n = 0;
        end
    endtask

    function automatic logic [CW+4:0] exp_vec();
        return {CW'(m_cr), m_v, m_n, m_d, m_rej, m_busy};
    endfunction

    task automatic step(input bit r, input bit bn, input bit bd, input bit bq, input bit bc);
        rst = r; nb = bn; db = bd; qb = bq; cancel = bc;
        @(posedge clk);
        model_edge(r, bn, bd, bq, bc);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        n_total++;
        if ({credit, vend, chg_n, chg_d, reject, busy} !== '0)
            $display("FAIL reset: got %h want 0", {credit, vend, chg_n, chg_d, reject, busy});
        else n_pass++;
        step(0, 0, 0, 0, 0);
        n_total++;
        if ({credit, vend, chg_n, chg_d, reject, busy} !== exp_vec())
            $display("FAIL reset_idle: got %h want %h", {credit, vend, chg_n, chg_d, reject, busy}, exp_vec());
        else n_pass++;
    endtask

    task automatic test_nickels();
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0);
            n_total++;
            if (i < 4 ? (credit !== CW'(i + 1) || vend !== 1'b0) : (vend !== 1'b1))
                $display("FAIL nickels_step%0d: got credit %0d vend %b", i, credit, vend);
            else n_pass++;
            step(0, 0, 0, 0, 0);
            n_total++;
            if ({credit, vend, chg_n, chg_d, reject, busy} !== exp_vec())
                $display("FAIL nickels_gap%0d: got %h want %h", i, {credit, vend, chg_n, chg_d, reject, busy}, exp_vec());
            else n_pass++;
        end
        n_total++;
        if (credit !== '0 || busy !== 1'b0 || chg_n !== 1'b0 || chg_d !== 1'b0)
            $display("FAIL nickels_end: got credit %0d busy %b", credit, busy);
        else n_pass++;
    endtask

    task automatic test_dimes();
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        n_total++;
        if (vend !== 1'b1 || credit !== CW'(6))
            $display("FAIL dimes_vend: got vend %b credit %0d want 1/6", vend, credit);
        else n_pass++;
        step(0, 0, 0, 0, 0);
        n_total++;
        if (chg_n !== 1'b1 || chg_d !== 1'b0 || {credit, vend, chg_n, chg_d, reject, busy} !== exp_vec())
            $display("FAIL dimes_chg_n: got %h want %h", {credit, vend, chg_n, chg_d, reject, busy}, exp_vec());
        else n_pass++;
        step(0, 0, 0, 0, 0);
        n_total++;
        if (busy !== 1'b0 || credit !== '0)
            $display("FAIL dimes_idle: got busy %b credit %0d", busy, credit);
        else n_pass++;
    endtask

    task automatic test_dime_quarter();
        int nbusy, nd;
        nbusy = 0; nd = 0;
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            nbusy += int'(busy);
            nd    += int'(chg_d);
            n_total++;
            if ({credit, vend, chg_n, chg_d, reject, busy} !== exp_vec())
                $display("FAIL dq_cycle%0d: got %h want %h", i, {credit, vend, chg_n, chg_d, reject, busy}, exp_vec());
            else n_pass++;
            step(0, 0, 0, 0, 0);
        end
        n_total++;
        if (nbusy !== 3 || nd !== 2)
            $display("FAIL dq_counts: got busy %0d dimes %0d want 3/2", nbusy, nd);
        else n_pass++;
    endtask

    task automatic test_multi_coin();
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 1, 0);
        n_total++;
        if (vend !== 1'b1 || reject !== 1'b1 || credit !== CW'(7))
            $display("FAIL multi_vend: got vend %b reject %b credit %0d want 1/1/7", vend, reject, credit);
        else n_pass++;
        step(0, 1, 0, 0, 0);
        n_total++;
        if (chg_d !== 1'b1 || reject !== 1'b1 || credit !== CW'(2))
            $display("FAIL multi_vend_coin: got chg_d %b reject %b credit %0d", chg_d, reject, credit);
        else n_pass++;
        step(0, 0, 1, 0, 0);
        n_total++;
        if (reject !== 1'b1 || credit !== '0 || chg_d !== 1'b0 || chg_n !== 1'b0)
            $display("FAIL multi_change_coin: got reject %b credit %0d", reject, credit);
        else n_pass++;
        step(0, 0, 0, 0, 0);
        n_total++;
        if ({credit, vend, chg_n, chg_d, reject, busy} !== exp_vec())
            $display("FAIL multi_after: got %h want %h", {credit, vend, chg_n, chg_d, reject, busy}, exp_vec());
        else n_pass++;
    endtask

    task automatic test_cancel();
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
`ifdef VEND_CANCEL_EN
        n_total++;
        if (chg_d !== 1'b1 || vend !== 1'b0)
            $display("FAIL cancel_dime: got chg_d %b vend %b", chg_d, vend);
        else n_pass++;
        step(0, 0, 0, 0, 0);
        n_total++;
        if (chg_n !== 1'b1 || vend !== 1'b0)
            $display("FAIL cancel_nickel: got chg_n %b vend %b", chg_n, vend);
        else n_pass++;
        step(0, 0, 0, 0, 0);
        n_total++;
        if (credit !== '0 || busy !== 1'b0)
            $display("FAIL cancel_idle: got credit %0d busy %b", credit, busy);
        else n_pass++;
`else
        step(0, 0, 0, 0, 1);
        n_total++;
        if (credit !== CW'(3) || busy !== 1'b0 || chg_d !== 1'b0 || chg_n !== 1'b0)
            $display("FAIL cancel_hold: got credit %0d busy %b want 3/0", credit, busy);
        else n_pass++;
`endif
        step(1, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        n_total++;
        if (chg_d !== 1'b1 || credit !== CW'(4))
            $display("FAIL rstmid_pre: got chg_d %b credit %0d want 1/4", chg_d, credit);
        else n_pass++;
        step(1, 0, 0, 0, 0);
        n_total++;
        if (credit !== '0 || busy !== 1'b0 || chg_d !== 1'b0 || chg_n !== 1'b0)
            $display("FAIL rstmid_post: got credit %0d busy %b", credit, busy);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            n_total++;
            if (chg_d !== 1'b0 || chg_n !== 1'b0 || vend !== 1'b0)
                $display("FAIL rstmid_quiet%0d: got chg_d %b chg_n %b vend %b", i, chg_d, chg_n, vend);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bit r, bn, bd, bq, bc;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(63) == 0);
            bn = ($urandom_range(3) == 0);
            bd = ($urandom_range(4) == 0);
            bq = ($urandom_range(7) == 0);
            bc = ($urandom_range(9) == 0);
            step(r, bn, bd, bq, bc);
            n_total++;
            if ({credit, vend, chg_n, chg_d, reject, busy} !== exp_vec())
                $display("FAIL random_cyc%0d: got %h want %h", i, {credit, vend, chg_n, chg_d, reject, busy}, exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; nb = 1'b0; db = 1'b0; qb = 1'b0; cancel = 1'b0;
        m_busy = 0; m_v = 0; m_d = 0; m_n = 0; m_rej = 0; m_cr = 0;
        test_reset();
        test_nickels();
        test_dimes();
        test_dime_quarter();
        test_multi_coin();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
